// File: rtl/elevator_ctrl.sv
// Mech-triggered vertical platform: moves between Y_TOP and Y_BOTTOM on frame_tick, publishes terrain props, carry/step flags and sprite address.
// Optional ELEV_HOLD_EN: the platform dwells HOLD_FRAMES at the top after release and ignores release while rising.
module elevator_ctrl #(
    parameter logic [9:0] X_POS    = 10'd200,
    parameter logic [9:0] Y_TOP    = 10'd120,
    parameter logic [9:0] Y_BOTTOM = 10'd300,
    parameter logic [9:0] WIDTH    = 10'd64,
    parameter logic [9:0] HEIGHT   = 10'd16,
    parameter logic [3:0] SPEED    = 4'd2
`ifdef ELEV_HOLD_EN
    ,
    parameter logic [7:0] HOLD_FRAMES = 8'd60
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        trigger,
    input  logic [39:0] player1_props,
    input  logic [39:0] player2_props,
    input  logic [9:0]  disp_h,
    input  logic [9:0]  disp_v,
    output logic [39:0] elev_props,
    output logic        carry_p1,
    output logic        carry_p2,
    output logic        step_up,
    output logic        step_down,
    output logic        at_top,
    output logic        in_sprite,
    output logic [16:0] addr
);

    typedef enum logic [1:0] {DOWN, RISING, UP, FALLING} state_t;

    localparam logic [10:0] SPEED_W = {7'd0, SPEED};
    localparam logic [10:0] X_END   = {1'b0, X_POS} + {1'b0, WIDTH};

    state_t      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic        step_up_q, step_up_d, step_dn_q, step_dn_d;
    logic        carry1_q, carry1_d, carry2_q, carry2_d;
    logic        in_sprite_q, in_sprite_d;
    logic [16:0] addr_q, addr_d;
    logic        rise_abort, rise_clamp, fall_clamp, blocked;
    logic [9:0]  dv, dh;
    logic [19:0] pix_ofs;

    // 11-bit compares throughout so edges near 1023 never wrap.
    function automatic logic x_overlap(input logic [39:0] p);
        return ({1'b0, p[39:30]} < X_END) &&
               (({1'b0, p[39:30]} + {1'b0, p[19:10]}) > {1'b0, X_POS});
    endfunction

    function automatic logic is_blocked(input logic [39:0] p, input logic [9:0] y);
        logic [10:0] lo;
        lo = {1'b0, y} + {1'b0, HEIGHT};
        return x_overlap(p) && ({1'b0, p[29:20]} >= lo) && ({1'b0, p[29:20]} < lo + SPEED_W);
    endfunction

    function automatic logic is_carried(input logic [39:0] p, input logic [9:0] y);
        return x_overlap(p) && (({1'b0, p[29:20]} + {1'b0, p[9:0]}) == {1'b0, y});
    endfunction

`ifdef ELEV_HOLD_EN
    logic [7:0] hold_q, hold_d;
    logic       holding_q, holding_d;
    assign rise_abort = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            holding_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            holding_q <= holding_d;
        end
    end
`else
    assign rise_abort = !trigger;
`endif

    assign rise_clamp = ({1'b0, y_q} <= ({1'b0, Y_TOP} + SPEED_W));
    assign fall_clamp = (({1'b0, y_q} + SPEED_W) >= {1'b0, Y_BOTTOM});
    assign blocked    = is_blocked(player1_props, y_q) || is_blocked(player2_props, y_q);

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
`ifdef ELEV_HOLD_EN
        hold_d    = hold_q;
        holding_d = holding_q;
`endif
        if (frame_tick) begin
            case (state_q)
                DOWN: if (trigger) state_d = RISING;
                RISING: begin
                    if (rise_abort) begin
                        state_d = FALLING;
                    end else if (rise_clamp) begin
                        y_d       = Y_TOP;
                        step_up_d = 1'b1;
                        state_d   = UP;
                    end else begin
                        y_d       = y_q - {6'd0, SPEED};
                        step_up_d = 1'b1;
                    end
                end
                UP: begin
`ifdef ELEV_HOLD_EN
                    // A re-press freezes the countdown; the next release continues it.
                    if (!trigger) begin
                        if (!holding_q) begin
                            hold_d    = HOLD_FRAMES;
                            holding_d = 1'b1;
                        end else if (hold_q <= 8'd1) begin
                            hold_d    = 8'd0;
                            holding_d = 1'b0;
                            state_d   = FALLING;
                        end else begin
                            hold_d = hold_q - 8'd1;
                        end
                    end
`else
                    if (!trigger) state_d = FALLING;
`endif
                end
                FALLING: begin
                    if (trigger) begin
                        state_d = RISING;
                    end else if (blocked) begin
                        state_d = FALLING;
                    end else if (fall_clamp) begin
                        y_d       = Y_BOTTOM;
                        step_dn_d = 1'b1;
                        state_d   = DOWN;
                    end else begin
                        y_d       = y_q + {6'd0, SPEED};
                        step_dn_d = 1'b1;
                    end
                end
                default: state_d = DOWN;
            endcase
        end
    end

    always_comb begin
        carry1_d    = is_carried(player1_props, y_q);
        carry2_d    = is_carried(player2_props, y_q);
        dv          = disp_v - y_q;
        dh          = disp_h - X_POS;
        pix_ofs     = {10'd0, dv} * {10'd0, WIDTH} + {10'd0, dh};
        in_sprite_d = ({1'b0, disp_h} >= {1'b0, X_POS}) && ({1'b0, disp_h} < X_END) &&
                      ({1'b0, disp_v} >= {1'b0, y_q}) &&
                      ({1'b0, disp_v} < ({1'b0, y_q} + {1'b0, HEIGHT}));
        addr_d      = in_sprite_d ? pix_ofs[16:0] : 17'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DOWN;
            y_q         <= Y_BOTTOM;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            carry1_q    <= 1'b0;
            carry2_q    <= 1'b0;
            in_sprite_q <= 1'b0;
            addr_q      <= 17'd0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            carry1_q    <= carry1_d;
            carry2_q    <= carry2_d;
            in_sprite_q <= in_sprite_d;
            addr_q      <= addr_d;
        end
    end

    assign elev_props = {X_POS, y_q, WIDTH, HEIGHT};
    assign carry_p1   = carry1_q;
    assign carry_p2   = carry2_q;
    assign step_up    = step_up_q;
    assign step_down  = step_dn_q;
    assign at_top     = (state_q == UP);
    assign in_sprite  = in_sprite_q;
    assign addr       = addr_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl (default build): a frame-level model queues expected position/pulses per tick.
module tb_elevator_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        trigger = 1'b0;
    logic [39:0] player1_props, player2_props;
    logic [9:0]  disp_h, disp_v;
    logic [39:0] elev_props;
    logic        carry_p1, carry_p2, step_up, step_down, at_top, in_sprite;
    logic [16:0] addr;

    elevator_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .trigger(trigger),
        .player1_props(player1_props), .player2_props(player2_props),
        .disp_h(disp_h), .disp_v(disp_v), .elev_props(elev_props),
        .carry_p1(carry_p1), .carry_p2(carry_p2), .step_up(step_up),
        .step_down(step_down), .at_top(at_top), .in_sprite(in_sprite), .addr(addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] y;
        logic       up;
        logic       dn;
        logic       top;
    } frame_exp_t;

    typedef struct packed {
        logic        ins;
        logic [16:0] addr;
    } pix_exp_t;

    frame_exp_t fq[$];
    pix_exp_t   pq[$];
    int checks = 0;
    int passed = 0;
    int m_state = 0;   // 0 DOWN, 1 RISING, 2 UP, 3 FALLING
    int m_y = 300;
    int n_up = 0;
    int n_dn = 0;

    function automatic bit m_overlap(input logic [39:0] p);
        int x, w;
        x = p[39:30];
        w = p[19:10];
        return (x < 264) && (x + w > 200);
    endfunction

    function automatic bit m_blocked(input logic [39:0] p);
        int t;
        t = p[29:20];
        return m_overlap(p) && (t >= m_y + 16) && (t < m_y + 18);
    endfunction

    task automatic frame();
        frame_exp_t e, obs;
        bit up, dn;
        up = 0;
        dn = 0;
        case (m_state)
            0: if (trigger) m_state = 1;
            1: begin
                if (!trigger) m_state = 3;
                else if (m_y - 2 <= 120) begin m_y = 120; up = 1; m_state = 2; end
                else begin m_y = m_y - 2; up = 1; end
            end
            2: if (!trigger) m_state = 3;
            default: begin
                if (trigger) m_state = 1;
                else if (m_blocked(player1_props) || m_blocked(player2_props)) m_state = 3;
                else if (m_y + 2 >= 300) begin m_y = 300; dn = 1; m_state = 0; end
                else begin m_y = m_y + 2; dn = 1; end
            end
        endcase
        e.y = m_y[9:0];
        e.up = up;
        e.dn = dn;
        e.top = (m_state == 2);
        fq.push_back(e);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        e = fq.pop_front();
        obs = {elev_props[29:20], step_up, step_down, at_top};
        n_up += int'(step_up);
        n_dn += int'(step_down);
        checks++;
        if (obs !== e)
            $display("FAIL frame: y=%0d up=%b dn=%b top=%b, expected y=%0d up=%b dn=%b top=%b",
                     obs.y, obs.up, obs.dn, obs.top, e.y, e.up, e.dn, e.top);
        else passed++;
    endtask

    task automatic test_reset();
        player1_props = {10'd600, 10'd0, 10'd10, 10'd10};
        player2_props = {10'd700, 10'd0, 10'd10, 10'd10};
        disp_h = 10'd0;
        disp_v = 10'd0;
        #12;
        checks++;
        if (elev_props !== {10'd200, 10'd300, 10'd64, 10'd16}) $display("FAIL reset_props: got %h, expected %h", elev_props, {10'd200, 10'd300, 10'd64, 10'd16});
        else passed++;
        checks++;
        if ({carry_p1, carry_p2, step_up, step_down, at_top, in_sprite, addr} !== 23'd0)
            $display("FAIL reset_outputs: got %b, expected all zero", {carry_p1, carry_p2, step_up, step_down, at_top, in_sprite, addr});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rise();
        trigger = 1'b1;
        n_up = 0;
        frame();
        repeat (75) frame();
        checks++;
        if (elev_props[29:20] !== 10'd150) $display("FAIL rise_75: y=%0d, expected 150", elev_props[29:20]);
        else passed++;
        repeat (15) frame();
        checks++;
        if (elev_props[29:20] !== 10'd120 || at_top !== 1'b1)
            $display("FAIL rise_top: y=%0d at_top=%b, expected 120 and 1", elev_props[29:20], at_top);
        else passed++;
        checks++;
        if (n_up !== 90) $display("FAIL rise_pulses: %0d step_up pulses, expected 90", n_up);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (step_up !== 1'b0) $display("FAIL pulse_width: step_up=%b, expected 0", step_up);
        else passed++;
    endtask

    task automatic test_fall();
        trigger = 1'b0;
        n_dn = 0;
        frame();
        repeat (90) frame();
        checks++;
        if (elev_props[29:20] !== 10'd300 || at_top !== 1'b0)
            $display("FAIL fall_bottom: y=%0d at_top=%b, expected 300 and 0", elev_props[29:20], at_top);
        else passed++;
        checks++;
        if (n_dn !== 90) $display("FAIL fall_pulses: %0d step_down pulses, expected 90", n_dn);
        else passed++;
        frame();
    endtask

    task automatic test_reverse();
        trigger = 1'b1;
        frame();
        repeat (50) frame();
        checks++;
        if (elev_props[29:20] !== 10'd200) $display("FAIL rev_start: y=%0d, expected 200", elev_props[29:20]);
        else passed++;
        trigger = 1'b0;
        frame();
        checks++;
        if (elev_props[29:20] !== 10'd200 || step_up !== 1'b0 || step_down !== 1'b0)
            $display("FAIL rev_pause: y=%0d up=%b dn=%b, expected 200 0 0", elev_props[29:20], step_up, step_down);
        else passed++;
        frame();
        checks++;
        if (elev_props[29:20] !== 10'd202) $display("FAIL rev_fall: y=%0d, expected 202", elev_props[29:20]);
        else passed++;
    endtask

    task automatic test_blocked();
        logic [9:0] yy;
        yy = 10'(m_y + 16);
        player2_props = {10'd210, yy, 10'd20, 10'd30};
        repeat (3) frame();
        checks++;
        if (elev_props[29:20] !== 10'd202 || step_down !== 1'b0)
            $display("FAIL blocked_hold: y=%0d dn=%b, expected 202 0", elev_props[29:20], step_down);
        else passed++;
        player2_props = {10'd400, yy, 10'd20, 10'd30};
        frame();
        checks++;
        if (elev_props[29:20] !== 10'd204 || step_down !== 1'b1)
            $display("FAIL blocked_release: y=%0d dn=%b, expected 204 1", elev_props[29:20], step_down);
        else passed++;
        for (int i = 0; i < 200 && m_state != 0; i++) frame();
        checks++;
        if (elev_props[29:20] !== 10'd300) $display("FAIL blocked_settle: y=%0d, expected 300", elev_props[29:20]);
        else passed++;
    endtask

    task automatic test_carry();
        player1_props = {10'd190, 10'd270, 10'd20, 10'd30};
        player2_props = {10'd250, 10'd280, 10'd40, 10'd20};
        @(posedge clk);
        #1;
        checks++;
        if (carry_p1 !== 1'b1 || carry_p2 !== 1'b1)
            $display("FAIL carry_on: p1=%b p2=%b, expected 1 1", carry_p1, carry_p2);
        else passed++;
        player1_props = {10'd300, 10'd270, 10'd20, 10'd30};
        player2_props = {10'd700, 10'd0, 10'd10, 10'd10};
        @(posedge clk);
        #1;
        checks++;
        if (carry_p1 !== 1'b0 || carry_p2 !== 1'b0)
            $display("FAIL carry_off: p1=%b p2=%b, expected 0 0", carry_p1, carry_p2);
        else passed++;
        player1_props = {10'd180, 10'd270, 10'd20, 10'd30};
        @(posedge clk);
        #1;
        checks++;
        if (carry_p1 !== 1'b0) $display("FAIL carry_edge: p1=%b, expected 0", carry_p1);
        else passed++;
        player1_props = {10'd600, 10'd0, 10'd10, 10'd10};
    endtask

    task automatic test_pixel();
        logic [9:0]  th[6] = '{10'd205, 10'd264, 10'd263, 10'd200, 10'd200, 10'd199};
        logic [9:0]  tv[6] = '{10'd310, 10'd310, 10'd315, 10'd316, 10'd300, 10'd305};
        logic        ti[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [16:0] ta[6] = '{17'd645, 17'd0, 17'd1023, 17'd0, 17'd0, 17'd0};
        pix_exp_t e;
        for (int i = 0; i < 6; i++) begin
            disp_h = th[i];
            disp_v = tv[i];
            e.ins = ti[i];
            e.addr = ta[i];
            pq.push_back(e);
            @(posedge clk);
            #1;
            e = pq.pop_front();
            checks++;
            if (in_sprite !== e.ins || addr !== e.addr)
                $display("FAIL pixel_%0d: in_sprite=%b addr=%0d, expected %b %0d", i, in_sprite, addr, e.ins, e.addr);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        trigger = 1'b1;
        frame();
        repeat (10) frame();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (elev_props[29:20] !== 10'd300 || step_up !== 1'b0 || at_top !== 1'b0)
            $display("FAIL reset_mid: y=%0d up=%b top=%b, expected 300 0 0", elev_props[29:20], step_up, at_top);
        else passed++;
        m_state = 0;
        m_y = 300;
        trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_reverse();
        test_blocked();
        test_carry();
        test_pixel();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
